// File: rtl/demux_disp_pkg.sv
// Shared types and constants for the round-robin demux dispatcher.
package demux_disp_pkg;

    localparam int NUM_CH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef logic [1:0] ch_idx_t;

endpackage

// File: rtl/rr_next_channel.sv
// Combinational round-robin pointer: next set mask bit above cur with wrap,
// or the lowest set bit when from_start is high.
module rr_next_channel
    import demux_disp_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  ch_idx_t           cur,
    input  logic              from_start,
    output ch_idx_t           nxt
);

    ch_idx_t cand;

    always_comb begin
        nxt  = cur;
        cand = '0;
        if (from_start) begin
            nxt = '0;
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (mask[i]) nxt = ch_idx_t'(i);
            end
        end else begin
            // Descending offsets so the nearest enabled channel wins; an
            // only-enabled channel falls through and keeps cur.
            for (int i = NUM_CH - 1; i >= 1; i--) begin
                cand = cur + ch_idx_t'(i);
                if (mask[cand]) nxt = cand;
            end
        end
    end

endmodule

// File: rtl/demux_rr_dispatcher.sv
// Round-robin dispatcher feeding a 1-to-4 demux in bursts of BURST beats.
// Optional per-channel beat counters are built when DEMUX_DISP_COUNT_EN is defined.
//
// state | meaning
// IDLE  | not dispatching, in_ready low
// RUN   | accepting beats, rotating channels every BURST beats
// FLUSH | stop seen mid-burst, finishing the current burst
module demux_rr_dispatcher
    import demux_disp_pkg::*;
#(
    parameter int BURST = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [3:0]       ch_mask,
    input  logic             in_valid,
    input  logic             in_data,
    output logic             in_ready,
    output logic             D,
    output logic             S0,
    output logic             S1,
    output logic             EN,
    output logic             busy,
    output logic             err,
    input  logic [1:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_out
);

    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BW-1:0] LAST = BW'(BURST - 1);

    state_t              state;
    ch_idx_t             ptr;
    logic [BW-1:0]       beat_cnt;
    logic [NUM_CH-1:0]   mask_q;
    ch_idx_t             start_ptr;
    ch_idx_t             adv_ptr;
    logic                accept;
    logic                last_beat;
    logic                start_ok;

    assign in_ready  = (state != IDLE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid & in_ready;
    assign last_beat = (beat_cnt == LAST);
    assign start_ok  = (state == IDLE) && start && (ch_mask != '0);

    rr_next_channel u_start_ch (
        .mask       (ch_mask),
        .cur        (2'd0),
        .from_start (1'b1),
        .nxt        (start_ptr)
    );

    rr_next_channel u_adv_ch (
        .mask       (mask_q),
        .cur        (ptr),
        .from_start (1'b0),
        .nxt        (adv_ptr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            beat_cnt <= '0;
            mask_q   <= '0;
            D        <= 1'b0;
            S0       <= 1'b0;
            S1       <= 1'b0;
            EN       <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            if (accept) begin
                D        <= in_data;
                S0       <= ptr[0];
                S1       <= ptr[1];
                EN       <= 1'b1;
                if (last_beat) begin
                    beat_cnt <= '0;
                    ptr      <= adv_ptr;
                end else begin
                    beat_cnt <= beat_cnt + BW'(1);
                end
            end else begin
                D  <= 1'b0;
                EN <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (ch_mask != '0) begin
                            mask_q   <= ch_mask;
                            ptr      <= start_ptr;
                            beat_cnt <= '0;
                            state    <= RUN;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        if (!accept && beat_cnt == '0)
                            state <= IDLE;
                        else if (accept && last_beat)
                            state <= IDLE;
                        else
                            state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (accept && last_beat) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DEMUX_DISP_COUNT_EN
    logic [CNT_W-1:0] cnt [NUM_CH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
        end else if (start_ok) begin
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
        end else if (accept && cnt[ptr] != '1) begin
            cnt[ptr] <= cnt[ptr] + CNT_W'(1);
        end
    end

    assign cnt_out = cnt[cnt_sel];
`else
    logic unused_cnt;
    assign unused_cnt = ^{cnt_sel, start_ok};
    assign cnt_out    = '0;
`endif

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Directed scoreboard bench for demux_rr_dispatcher (BURST=4, CNT_W=4).
module tb_demux_rr_dispatcher;
    import demux_disp_pkg::*;

    localparam int BURST = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start, stop;
    logic [3:0]       ch_mask;
    logic             in_valid, in_data;
    logic             in_ready, D, S0, S1, EN, busy, err;
    logic [1:0]       cnt_sel;
    logic [CNT_W-1:0] cnt_out;

    int checks   = 0;
    int failures = 0;
    logic [2:0] sb_q[$];
    logic [2:0] exp_beat;
    logic [1:0] exp_sel;

    demux_rr_dispatcher #(.BURST(BURST), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .ch_mask(ch_mask),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .D(D), .S0(S0), .S1(S1), .EN(EN), .busy(busy), .err(err),
        .cnt_sel(cnt_sel), .cnt_out(cnt_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic d, input logic [1:0] ch);
        chk("in_ready_before_beat", in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        sb_q.push_back({d, ch});
        step();
        in_valid = 1'b0;
        chk("en_after_beat", EN, 1);
        if (sb_q.size() == 0) begin
            chk("scoreboard_underflow", 0, 1);
        end else begin
            exp_beat = sb_q.pop_front();
            chk("d_after_beat", D, exp_beat[2]);
            chk("sel_after_beat", {S1, S0}, exp_beat[1:0]);
            exp_sel = exp_beat[1:0];
        end
    endtask

    task automatic gap();
        in_valid = 1'b0;
        step();
        chk("en_gap", EN, 0);
        chk("d_gap", D, 0);
        chk("sel_hold_gap", {S1, S0}, exp_sel);
    endtask

    task automatic check_counters(input logic [CNT_W-1:0] e0, input logic [CNT_W-1:0] e1,
                                  input logic [CNT_W-1:0] e2, input logic [CNT_W-1:0] e3);
        logic [CNT_W-1:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int i = 0; i < 4; i++) begin
            cnt_sel = 2'(i);
            #1;
`ifdef DEMUX_DISP_COUNT_EN
            chk("cnt_out", cnt_out, e[i]);
`else
            chk("cnt_out_tied", cnt_out, 0);
`endif
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; ch_mask = 4'h0;
        in_valid = 1'b0; in_data = 1'b0; cnt_sel = 2'd0; exp_sel = 2'd0;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_D", D, 0); chk("rst_sel", {S1, S0}, 0); chk("rst_EN", EN, 0);
        chk("rst_in_ready", in_ready, 0); chk("rst_busy", busy, 0); chk("rst_err", err, 0);
        check_counters(0, 0, 0, 0);

        // All four channels, 16 alternating beats
        start = 1'b1; ch_mask = 4'b1111;
        step();
        start = 1'b0;
        chk("t1_busy", busy, 1); chk("t1_err", err, 0); chk("t1_en_idle", EN, 0);
        for (int k = 0; k < 16; k++) drive_beat(~k[0], 2'(k / 4));
        gap();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t1_stop_busy", busy, 0); chk("t1_stop_ready", in_ready, 0);

        // Mask 1010, start mid-run ignored, then stop two beats into a burst
        start = 1'b1; ch_mask = 4'b1010;
        step();
        start = 1'b0; ch_mask = 4'b0000;
        for (int k = 0; k < 9; k++) begin
            if (k == 5) begin start = 1'b1; ch_mask = 4'b0001; end
            drive_beat(k[1], (k < 4 || k >= 8) ? 2'd1 : 2'd3);
            start = 1'b0; ch_mask = 4'b0000;
        end
        stop = 1'b1;
        drive_beat(1'b1, 2'd1);
        stop = 1'b0;
        chk("t2_flush_busy", busy, 1);
        drive_beat(1'b0, 2'd1);
        chk("t2_flush_busy2", busy, 1);
        drive_beat(1'b1, 2'd1);
        chk("t2_done_busy", busy, 0); chk("t2_done_ready", in_ready, 0);
        gap();

        // Start with empty mask
        start = 1'b1; ch_mask = 4'b0000;
        step();
        start = 1'b0;
        chk("t3_err", err, 1); chk("t3_busy", busy, 0); chk("t3_en", EN, 0);
        step();
        chk("t3_err_clear", err, 0); chk("t3_busy2", busy, 0);

        // Start+stop together, then beats with gaps on mask 0110
        start = 1'b1; stop = 1'b1; ch_mask = 4'b0110;
        step();
        start = 1'b0; stop = 1'b0;
        chk("t4_start_wins", busy, 1);
        for (int j = 0; j < 8; j++) begin
            drive_beat(j[0], (j < 4) ? 2'd1 : 2'd2);
            gap();
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t4_stop_busy", busy, 0);

        // Counters on single channel, saturation, then reset mid-burst
        start = 1'b1; ch_mask = 4'b0001;
        step();
        start = 1'b0;
        check_counters(0, 0, 0, 0);
        for (int k = 0; k < 10; k++) drive_beat(k[0], 2'd0);
        check_counters(10, 0, 0, 0);
        for (int k = 0; k < 8; k++) drive_beat(k[1], 2'd0);
        check_counters(15, 0, 0, 0);
        cnt_sel = 2'd0;
        rst = 1'b1;
        #1;
        chk("rst_mid_EN", EN, 0); chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ready", in_ready, 0); chk("rst_mid_D", D, 0);
        check_counters(0, 0, 0, 0);
        rst = 1'b0;
        step();
        chk("post_rst_EN", EN, 0); chk("post_rst_busy", busy, 0);
        chk("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
